// File: rtl/branch_pkg.sv
// Shared definitions for the EX-stage branch resolution block:
// funct3 encodings, FSM state type and statistics counter width.
package branch_pkg;

  localparam int CNT_W = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    TRAP  = 2'd2
  } br_state_e;

  // Reserved encodings 010/011 never take and never redirect.
  function automatic logic f3_is_branch(input logic [2:0] f3);
    return (f3[2:1] != 2'b01);
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic less,
                                    input logic equal);
    logic t;
    t = 1'b0;
    case (f3)
      F3_BEQ:           t = equal;
      F3_BNE:           t = !equal;
      F3_BLT, F3_BLTU:  t = less;
      F3_BGE, F3_BGEU:  t = !less;
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// EX-stage bundle between the pipeline (master) and branch_resolve (slave).
// Statistics ports exist in every build; they read 0 unless BRANCH_STATS_EN.
interface branch_resolve_if #(parameter int N = 31);
  import branch_pkg::*;

  logic             ex_valid_i;
  logic             ex_stall_i;
  logic             ex_is_br_i;
  logic             ex_is_jal_i;
  logic             ex_is_jalr_i;
  logic [2:0]       ex_funct3_i;
  logic [N:0]       ex_pc_i;
  logic [N:0]       ex_imm_i;
  logic [N:0]       rs1_data_i;
  logic             br_less_i;
  logic             br_equal_i;
  logic             pred_taken_i;
  logic [N:0]       pred_pc_i;
  logic             trap_ack_i;
  logic             br_unsigned_o;
  logic             redirect_o;
  logic [N:0]       redirect_pc_o;
  logic             flush_o;
  logic             misalign_o;
  logic [CNT_W-1:0] br_count_o;
  logic [CNT_W-1:0] mispred_count_o;

  modport master (
    output ex_valid_i, ex_stall_i, ex_is_br_i, ex_is_jal_i, ex_is_jalr_i,
           ex_funct3_i, ex_pc_i, ex_imm_i, rs1_data_i, br_less_i, br_equal_i,
           pred_taken_i, pred_pc_i, trap_ack_i,
    input  br_unsigned_o, redirect_o, redirect_pc_o, flush_o, misalign_o,
           br_count_o, mispred_count_o
  );

  modport slave (
    input  ex_valid_i, ex_stall_i, ex_is_br_i, ex_is_jal_i, ex_is_jalr_i,
           ex_funct3_i, ex_pc_i, ex_imm_i, rs1_data_i, br_less_i, br_equal_i,
           pred_taken_i, pred_pc_i, trap_ack_i,
    output br_unsigned_o, redirect_o, redirect_pc_o, flush_o, misalign_o,
           br_count_o, mispred_count_o
  );

endinterface

// File: rtl/branch_resolve_target.sv
// Combinational target and fall-through address generation.
// JALR adds to rs1 and clears bit 0; branches and JAL add to the PC.
module branch_target #(
  parameter int n = 31
) (
  input  logic [n:0] pc_i,
  input  logic [n:0] imm_i,
  input  logic [n:0] rs1_i,
  input  logic       is_jalr_i,
  output logic [n:0] target_o,
  output logic [n:0] fallthrough_o
);

  logic [n:0] base;
  logic [n:0] sum;

  assign base          = is_jalr_i ? rs1_i : pc_i;
  assign sum           = base + imm_i;
  assign target_o      = is_jalr_i ? {sum[n:1], 1'b0} : sum;
  assign fallthrough_o = pc_i + (n+1)'(4);

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch/jump resolution: decides taken/target, checks the IF
// prediction and issues a registered redirect+flush or a held misalign trap.
//
//   state | meaning
//   IDLE  | accepting resolve events
//   FLUSH | one-cycle redirect_o/flush_o pulse, EX slot is wrong-path
//   TRAP  | misalign_o held until trap_ack_i
module branch_resolve
  import branch_pkg::*;
#(
  parameter int n = 31
) (
  input  logic            clk_i,
  input  logic            rst_i,
  branch_resolve_if.slave bus
);

  br_state_e  state_q, state_d;
  logic [n:0] redirect_pc_q, redirect_pc_d;

  logic [n:0] target;
  logic [n:0] fallthrough;
  logic [n:0] actual_pc;
  logic       is_cf;
  logic       is_jump;
  logic       taken;
  logic       resolve;
  logic       mispredict;
  logic       misaligned;

  branch_target #(.n(n)) u_target (
    .pc_i          (bus.ex_pc_i),
    .imm_i         (bus.ex_imm_i),
    .rs1_i         (bus.rs1_data_i),
    .is_jalr_i     (bus.ex_is_jalr_i),
    .target_o      (target),
    .fallthrough_o (fallthrough)
  );

  assign is_jump    = bus.ex_is_jal_i | bus.ex_is_jalr_i;
  assign is_cf      = bus.ex_is_br_i | is_jump;
  assign taken      = is_jump |
                      (bus.ex_is_br_i &
                       br_taken(bus.ex_funct3_i, bus.br_less_i, bus.br_equal_i));
  assign actual_pc  = taken ? target : fallthrough;
  // pred_taken_i is implied by pred_pc_i; comparing addresses covers both
  // direction and target errors.
  assign mispredict = (is_jump | f3_is_branch(bus.ex_funct3_i)) &
                      (actual_pc != bus.pred_pc_i);
  assign misaligned = taken & (target[1:0] != 2'b00);
  assign resolve    = (state_q == IDLE) & bus.ex_valid_i & !bus.ex_stall_i & is_cf;

  assign bus.br_unsigned_o = bus.ex_is_br_i & bus.ex_funct3_i[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (resolve) begin
          if (misaligned) begin
            state_d = TRAP;
          end else if (mispredict) begin
            state_d       = FLUSH;
            redirect_pc_d = actual_pc;
          end
        end
      end
      FLUSH:   state_d = IDLE;
      TRAP:    if (bus.trap_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.redirect_o    = (state_q == FLUSH);
  assign bus.flush_o       = (state_q == FLUSH);
  assign bus.misalign_o    = (state_q == TRAP);
  assign bus.redirect_pc_o = redirect_pc_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mis_cnt_q;
  logic             enter_flush;

  assign enter_flush = (state_q == IDLE) & (state_d == FLUSH);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (resolve && (br_cnt_q != '1))      br_cnt_q  <= br_cnt_q + 1'b1;
      if (enter_flush && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + 1'b1;
    end
  end

  assign bus.br_count_o      = br_cnt_q;
  assign bus.mispred_count_o = mis_cnt_q;
`else
  assign bus.br_count_o      = '0;
  assign bus.mispred_count_o = '0;
`endif

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- EX-stage branch/jump resolution unit; consumer of the branch comparator outputs and producer of its signedness select.
- Decodes funct3 against br_less/br_equal, computes the actual target, and compares the outcome with the IF-stage prediction.
- On mismatch, issues a registered one-cycle PC redirect plus pipeline flush; on a misaligned taken target, raises a held trap request.

Parameters:
- n, 31, MSB index of data/PC path (width n+1)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- ex_valid_i  in  1  EX holds a valid instruction
- ex_stall_i  in  1  EX frozen this cycle; no resolution
- ex_is_br_i  in  1  conditional branch
- ex_is_jal_i  in  1  JAL
- ex_is_jalr_i  in  1  JALR
- ex_funct3_i  in  3  branch funct3
- ex_pc_i  in  n+1  instruction PC
- ex_imm_i  in  n+1  sign-extended immediate
- rs1_data_i  in  n+1  JALR base
- br_less_i  in  1  from comparator
- br_equal_i  in  1  from comparator
- pred_taken_i  in  1  IF prediction for this instruction
- pred_pc_i  in  n+1  PC that IF fetched next
- trap_ack_i  in  1  trap unit accepted misalign
- br_unsigned_o  out  1  to comparator
- redirect_o  out  1  select redirect_pc_o as next PC
- redirect_pc_o  out  n+1  corrected PC
- flush_o  out  1  squash IF/ID and the EX slot
- misalign_o  out  1  taken target not 4-byte aligned
- br_count_o  out  32  resolved control transfers (feature)
- mispred_count_o  out  32  mispredictions (feature)

Behaviour:
- Reset: state IDLE; redirect_o, flush_o and misalign_o are 0; redirect_pc_o is 0; counters are 0. Asynchronous reset aborts a pending FLUSH/TRAP immediately.
- br_unsigned_o: combinational, equals ex_funct3_i[1] (BLTU/BGEU). Driven 0 when ex_is_br_i is 0.
- Taken decode:
  - 000 equal; 001 !equal; 100 less; 101 !less; 110 less; 111 !less.
  - 010/011: not taken, no redirect.
  - JAL/JALR: always taken.
- Target arithmetic (modulo 2^(n+1), wrap-around ignored):
  - Branch/JAL: ex_pc_i + ex_imm_i.
  - JALR: (rs1_data_i + ex_imm_i) with bit0 cleared.
  - Fall-through: ex_pc_i + 4.
- Resolve event: IDLE AND ex_valid_i AND !ex_stall_i AND (is_br | is_jal | is_jalr).
  - actual_pc = taken ? target : fallthrough.
  - mispredict = (actual_pc != pred_pc_i), covering both direction and target errors.
- FSM IDLE:
  - Resolve with taken and target[1:0] != 0 -> TRAP. misalign_o=1 next cycle; no redirect.
  - Else resolve with mispredict -> FLUSH. redirect_o=1, flush_o=1, redirect_pc_o=actual_pc, all registered, asserted the next cycle.
  - Otherwise stay IDLE; outputs 0.
- FSM FLUSH:
  - Lasts exactly one cycle; ex_valid_i is ignored (wrong-path slot).
  - Next state IDLE; redirect_o/flush_o drop to 0.
  - ex_stall_i does not extend FLUSH.
- FSM TRAP:
  - misalign_o held 1; further resolves ignored.
  - trap_ack_i -> IDLE, misalign_o=0 next cycle.
- Simultaneous events: misalign has priority over mispredict. A stall in the resolve cycle suppresses the decision; evaluation happens on the first unstalled cycle.
- Latency: exactly 1 cycle from resolve edge to redirect/misalign.

Optional Feature:
- BRANCH_STATS_EN defined:
  - br_count_o increments on every resolve event.
  - mispred_count_o increments when entering FLUSH.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package branch_pkg:
  - funct3 localparams (BEQ, BNE, BLT, BGE, BLTU, BGEU).
  - State enum (IDLE, FLUSH, TRAP).
  - Counter width constant 32.
- Sub-module branch_target: purely combinational target/fall-through adders plus JALR bit0 clear. Instantiated once.

Test Plan:
- BEQ, pc=0x100, imm=0x20, equal=1, pred_taken=0, pred_pc=0x104 -> next cycle redirect_o=1, flush_o=1, redirect_pc_o=0x120; following cycle both 0.
- BLTU funct3=110, less=1, pred_pc=pc+imm -> br_unsigned_o=1; no redirect, no flush.
- JALR, rs1=0x203, imm=0x0 -> target 0x202 (bit0 cleared), misaligned -> misalign_o=1, held until trap_ack_i, cleared 1 cycle later; redirect_o stays 0.
- Mispredict resolve with ex_stall_i=1 for 3 cycles -> no outputs; redirect on the cycle after the stall releases.
- rst_i asserted during FLUSH -> redirect_o/flush_o drop immediately, state IDLE.
- With BRANCH_STATS_EN: 5 branches, 2 mispredicted -> br_count_o=5, mispred_count_o=2; without the macro both read 0.
